// File: rtl/credit_return_sink_pkg.sv
// rtl/credit_return_sink_pkg.sv - shared parameters and width helpers for the credit return sink
package credit_return_sink_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 5;
  localparam int DEF_RET_LAT = 3;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int CNT_W = cnt_w(DEF_DEPTH);
  localparam int PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/credit_delay_line.sv
// rtl/credit_delay_line.sv - fixed-latency 1-bit shift register turning pops into credit pulses
module credit_delay_line #(
  parameter int RET_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o
);

  logic [RET_LAT-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= in_i;
      for (int i = 1; i < RET_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign out_o = sr_q[RET_LAT-1];

endmodule

// File: rtl/credit_return_sink.sv
// rtl/credit_return_sink.sv - credit-limited token buffer: no-backpressure push, valid/ready drain, credit per pop
module credit_return_sink
  import credit_return_sink_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int RET_LAT = DEF_RET_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         credit_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow
);

  localparam int OCC_W = cnt_w(DEPTH);
  localparam int PW    = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, push_acc;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

  always_comb begin
    full     = (occ_q == OCC_W'(DEPTH));
    pop      = out_valid && out_ready;
    // A full buffer still accepts when the same cycle frees an entry.
    push_acc = in_valid && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
    if (in_valid && !push_acc) ovf_d = 1'b1;
    occ_d = occ_q + OCC_W'(push_acc) - OCC_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= in_data;
  end

  credit_delay_line #(
    .RET_LAT(RET_LAT)
  ) u_credit_delay_line (
    .clk  (clk),
    .rst  (rst),
    .in_i (pop),
    .out_o(credit_o)
  );

endmodule

// File: tb/tb_credit_return_sink.sv
// tb/tb_credit_return_sink.sv - queue-model bench for credit_return_sink with directed and random traffic
module tb_credit_return_sink;
  import credit_return_sink_pkg::*;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 5;
  localparam int RET_LAT = 3;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, credit_o, overflow;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  credit_return_sink #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RET_LAT(RET_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .credit_o(credit_o), .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  int               due[$];
  logic             m_ovf = 1'b0;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  logic             exp_credit;
  bit               inv_on = 1'b0;
  int               crd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    if (inv_on) check("invariant", 32'(int'(occupancy) + due.size() <= DEPTH), 32'd1);
    exp_credit = (due.size() != 0) && (due[0] == cyc);
    if (exp_credit) void'(due.pop_front());
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("credit_o", 32'(credit_o), 32'(exp_credit));
  endtask

  task automatic apply(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic rdy);
    bit popped;
    rst = r; in_valid = iv; in_data = d; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete(); due.delete(); m_ovf = 1'b0;
    end else begin
      popped = (q.size() != 0) && rdy;
      if (popped) begin
        void'(q.pop_front());
        due.push_back(cyc + RET_LAT);
      end
      if (iv) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic rdy);
    sample();
    apply(r, iv, d, rdy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // single token with immediate drain
    step(0, 1, 8'hA5, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // fill, overflow on sixth, then drain
    for (int i = 1; i <= 6; i++) step(0, 1, WIDTH'(i), 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // full with simultaneous push and pop
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, WIDTH'(8'h21 + i), 0);
    step(0, 1, 8'h10, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // streaming push+pop across pointer wrap
    for (int i = 0; i < 21; i++) step(0, 1, WIDTH'(8'h40 + i), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // reset while credits are pending
    for (int i = 0; i < 3; i++) step(0, 1, WIDTH'(8'h70 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // random traffic from a producer that respects the credit limit
    step(1, 0, 0, 0);
    inv_on = 1'b1;
    crd = DEPTH;
    for (int i = 0; i < 400; i++) begin
      logic iv;
      sample();
      if (exp_credit) crd++;
      iv = (crd > 0) && ($urandom_range(0, 3) != 0);
      if (iv) crd--;
      apply(0, iv, WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
